// File: rtl/sorted_word_unpacker_pkg.sv
// Shared constants for the odd-even sorter pipeline and its consumer-side unpacker.
// Element k of a packed word occupies bits [k*SORT_ELEM_W +: SORT_ELEM_W];
// element 0 is the largest value of a correctly sorted word.
package sorted_word_unpacker_pkg;

  localparam int SORT_ELEM_W = 2;
  localparam int SORT_N_ELEM = 4;
  localparam int SORT_WORD_W = SORT_ELEM_W * SORT_N_ELEM;

  // Extract element k from a packed word of the default geometry.
  function automatic logic [SORT_ELEM_W-1:0] sort_elem(input logic [SORT_WORD_W-1:0] word,
                                                       input int k);
    return word[k*SORT_ELEM_W +: SORT_ELEM_W];
  endfunction

endpackage

// File: rtl/sorted_word_unpacker_fifo.sv
// sort_word_fifo: single-clock word buffer for the sorted-word unpacker.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without an occupancy counter. The head word is presented combinationally.
import sorted_word_unpacker_pkg::*;

module sort_word_fifo #(
  parameter int WIDTH = SORT_WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;

  // Storage array is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointer advance; wrap-around relies on natural overflow of the extra bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + (AW+1)'(1);
      if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/sorted_word_unpacker.sv
// sorted_word_unpacker: buffers packed sorted words and serialises them one
// element per beat on a valid/ready stream with index and last markers.
// Optional feature macro: SORTED_ORDER_CHECK_EN enables the order_err check on
// accepted words; without it order_err is tied low.
import sorted_word_unpacker_pkg::*;

module sorted_word_unpacker #(
  parameter int ELEM_W     = SORT_ELEM_W,
  parameter int N_ELEM     = SORT_N_ELEM,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_ELEM*ELEM_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic [$clog2(N_ELEM)-1:0]  out_idx,
  output logic                       out_last,
  output logic                       drop_err,
  output logic                       order_err
);

  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int WORD_W = N_ELEM * ELEM_W;

  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_beat;
  logic              w_pop;
  logic [IDX_W-1:0]  r_idx;
  logic              r_drop_err;

  assign w_push = in_valid && !w_full;
  assign w_beat = out_valid && out_ready;
  assign w_pop  = w_beat && out_last;

  sort_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Element index within the head word: advance per beat, restart after the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_beat) begin
      r_idx <= out_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Sticky drop flag: the upstream sorter cannot stall, so a refused word is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_err <= 1'b0;
    end else if (in_valid && !w_full) begin
      r_drop_err <= r_drop_err;
    end else if (in_valid) begin
      r_drop_err <= 1'b1;
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_idx   = r_idx;
  assign out_last  = (r_idx == IDX_W'(N_ELEM-1));
  assign out_data  = w_empty ? '0 : w_head[r_idx*ELEM_W +: ELEM_W];
  assign drop_err  = r_drop_err;

`ifdef SORTED_ORDER_CHECK_EN
  logic w_unsorted;
  logic r_order_err;

  // Flag any adjacent pair where a later element exceeds an earlier one.
  always_comb begin
    w_unsorted = 1'b0;
    for (int k = 0; k < N_ELEM-1; k++) begin
      if (in_data[k*ELEM_W +: ELEM_W] < in_data[(k+1)*ELEM_W +: ELEM_W]) begin
        w_unsorted = 1'b1;
      end
    end
  end

  // One-cycle pulse after an accepted unsorted word; the word itself is still buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_order_err <= 1'b0;
    end else begin
      r_order_err <= w_push && w_unsorted;
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_word_unpacker.sv
// Testbench for sorted_word_unpacker. Stimulus is driven just after each rising
// edge; a monitor samples at the falling edge, maintains a word-level model of
// the buffer (queue of expected beats plus word count) and compares every output.
// Honours SORTED_ORDER_CHECK_EN the same way the design does.
module tb_sorted_word_unpacker;

  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
  logic       drop_err;
  logic       order_err;

  typedef struct {
    int data;
    int idx;
    bit last;
  } beat_t;

  beat_t expQ[$];
  int    mCount = 0;
  bit    expDrop = 1'b0;
  bit    expOrderNext = 1'b0;
  int    nChecks = 0;
  int    nFails = 0;

  sorted_word_unpacker #(
    .ELEM_W     (2),
    .N_ELEM     (4),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .drop_err  (drop_err),
    .order_err (order_err)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Single comparison with bookkeeping
  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input bit valid, input logic [7:0] data, input bit ready);
    @(posedge clk);
    #1;
    in_valid  = valid;
    in_data   = data;
    out_ready = ready;
  endtask

  // Hold rst_n low for n cycles, inputs idle
  task automatic applyReset(input int n);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random word whose elements are in descending order
  function automatic logic [7:0] sortedWord();
    int q[$];
    logic [7:0] w;
    for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 3)));
    q.rsort();
    w = '0;
    for (int k = 0; k < 4; k++) w = w | 8'(q[k] << (2*k));
    return w;
  endfunction

  // True when the word equals its own descending-sorted rearrangement
  function automatic bit isSorted(input logic [7:0] w);
    int q[$];
    int s[$];
    for (int k = 0; k < 4; k++) q.push_back(int'((w >> (2*k)) & 8'h3));
    s = q;
    s.rsort();
    return (q == s);
  endfunction

  // Let the consumer accept until the model is empty, bounded by a cycle budget
  task automatic waitDrain(input int budget);
    int c;
    c = 0;
    while (mCount > 0 && c < budget) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      c++;
    end
    if (mCount > 0) checkOutput("drain_timeout", mCount, 0);
  endtask

  // Monitor / scoreboard at the falling edge
  always @(negedge clk) begin
    bit    readyExp;
    beat_t e;
    if (!rst_n) begin
      expQ.delete();
      mCount       = 0;
      expDrop      = 1'b0;
      expOrderNext = 1'b0;
    end else begin
      readyExp = (mCount < FIFO_DEPTH);
      checkOutput("in_ready", int'(in_ready), int'(readyExp));
      checkOutput("out_valid", int'(out_valid), int'(expQ.size() != 0));
      checkOutput("drop_err", int'(drop_err), int'(expDrop));
      checkOutput("order_err", int'(order_err), int'(expOrderNext));
      expOrderNext = 1'b0;
      if (expQ.size() == 0) begin
        checkOutput("idle_out_data", int'(out_data), 0);
        checkOutput("idle_out_idx", int'(out_idx), 0);
        checkOutput("idle_out_last", int'(out_last), 0);
      end else begin
        e = expQ[0];
        checkOutput("out_data", int'(out_data), e.data);
        checkOutput("out_idx", int'(out_idx), e.idx);
        checkOutput("out_last", int'(out_last), int'(e.last));
        if (out_ready) begin
          void'(expQ.pop_front());
          if (e.last) mCount--;
        end
      end
      if (in_valid) begin
        if (readyExp) begin
          for (int k = 0; k < 4; k++) begin
            e.data = int'((in_data >> (2*k)) & 8'h3);
            e.idx  = k;
            e.last = (k == 3);
            expQ.push_back(e);
          end
          mCount++;
`ifdef SORTED_ORDER_CHECK_EN
          expOrderNext = !isSorted(in_data);
`endif
        end else begin
          expDrop = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [7:0] w;

    // Reset and idle
    applyReset(2);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Single sorted word, consumer always ready: 3,2,1,0
    applyStimulus(1'b1, 8'b00_01_10_11, 1'b1);
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b1);

    // Fill the buffer while stalled, then overflow once
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, sortedWord(), 1'b0);
    applyStimulus(1'b1, 8'b11_11_11_11, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitDrain(40);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Clear the sticky drop flag
    applyReset(1);

    // Back-to-back words every 4th cycle at full consumer rate
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, sortedWord(), 1'b1);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    end
    waitDrain(20);

    // Mid-word stall pattern 1,0,0,1
    applyStimulus(1'b1, 8'b00_01_10_11, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitDrain(20);

    // Unsorted word: emitted unchanged as 2,1,0,3
    applyStimulus(1'b1, 8'b11_00_01_10, 1'b1);
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b1);

    // Reset after two of four beats, then a fresh word
    applyStimulus(1'b1, 8'b01_10_10_11, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyReset(1);
    applyStimulus(1'b1, 8'b00_00_01_10, 1'b1);
    waitDrain(20);

    // Randomised traffic, occasionally unsorted, with back-pressure
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) == 0) ? 8'($urandom) : sortedWord();
      applyStimulus($urandom_range(0, 2) == 0, w, $urandom_range(0, 3) != 0);
    end
    waitDrain(100);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
